// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane geometry.
package load_store_unit_pkg;

  // Byte lanes in one 32-bit memory word, and bits per lane.
  localparam int unsigned LANES_PER_WORD = 4;
  localparam int unsigned LANE_BITS      = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // True when the size is reserved or the byte offset is not naturally aligned for it.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = |offset;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges sub-word store data.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [$clog2(LANES_PER_WORD)-1:0] addr,
  input  logic [1:0]                        size,
  input  logic                              is_unsigned,
  input  logic [31:0]                       word,
  input  logic [31:0]                       wdata,
  output logic [31:0]                       load_data,
  output logic [31:0]                       store_word
);

  logic [LANE_BITS-1:0] byte_val;
  logic [15:0]          half_val;
  logic [4:0]           bit_base;

  // Select the addressed lane, extend loads, and replace only that lane for stores.
  always_comb begin
    bit_base   = {addr, 3'b000};
    byte_val   = word[bit_base +: LANE_BITS];
    half_val   = addr[1] ? word[31:16] : word[15:0];
    load_data  = '0;
    store_word = word;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
        store_word[bit_base +: LANE_BITS] = wdata[LANE_BITS-1:0];
      end
      SIZE_HALF: begin
        load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
        if (addr[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      SIZE_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request port in, word-addressed memory port out.
// Sub-word stores are done as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned addresswidth = 32,
  parameter int unsigned depth        = 2**14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_error,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out
);

  state_e                  state_q, state_d;
  logic [1:0]              offset_q, offset_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic                    write_q, write_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [addresswidth-1:0] mem_address_q, mem_address_d;
  logic [31:0]             mem_data_in_q, mem_data_in_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_error_q, resp_error_d;

  logic                    req_err;
  logic [31:0]             load_data;
  logic [31:0]             store_word;

  assign req_err = size_misaligned(req_size, req_addr[1:0]) ||
                   ({2'b00, req_addr[31:2]} >= depth);

  // mem_data_out is only meaningful in READ, which is the only state whose results are used.
  lsu_lane_align u_lane_align (
    .addr        (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .word        (mem_data_out),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Next-state logic: accept/decode in IDLE, capture read data in READ, pulse response in RESP.
  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          offset_d   = req_addr[1:0];
          size_d     = req_size;
          unsigned_d = req_unsigned;
          write_d    = req_write;
          wdata_d    = req_wdata;
          if (req_err) begin
            // No strobe for a bad request; go straight to the error response.
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end else begin
            mem_address_d = addresswidth'(req_addr[31:2]);
            if (req_write && (req_size == SIZE_WORD)) begin
              mem_data_in_d = req_wdata;
              state_d       = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (write_q) begin
          mem_data_in_d = store_word;
          state_d       = ST_WRITE;
        end else begin
          resp_rdata_d = load_data;
          state_d      = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      offset_q      <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign mem_read_en  = (state_q == ST_READ);
  assign mem_write_en = (state_q == ST_WRITE);
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_error   = resp_error_q;
  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_in_q;

endmodule
